// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM controller.
// Arithmetic helpers work on int so callers can choose any CNT_W.
package pwm_pkg;

    typedef enum logic [1:0] {
        EVT_NONE = 2'd0,
        EVT_INC  = 2'd1,
        EVT_DEC  = 2'd2
    } duty_evt_e;

    // Largest duty value (100 %) and the last counter value before wrap.
    function automatic int duty_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 2;
    endfunction

    function automatic int sat_add(input int a, input int step, input int max_v);
        return ((a + step) > max_v) ? max_v : (a + step);
    endfunction

    function automatic int sat_sub(input int a, input int step);
        return (a < step) ? 0 : (a - step);
    endfunction

    // Simultaneous inc and dec cancel out.
    function automatic duty_evt_e decode_evt(input logic inc, input logic dec);
        if (inc && !dec) return EVT_INC;
        if (dec && !inc) return EVT_DEC;
        return EVT_NONE;
    endfunction

    function automatic int ch_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// One button: 2-flop synchroniser, level debouncer, press pulse and hold-to-repeat.
// o_pulse is a single-cycle pulse on an accepted press and on every repeat.
module pwm_btn_debounce #(
    parameter int DEB_CYC    = 4,
    parameter int REPEAT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam int REP_W = $clog2(REPEAT_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [REP_W-1:0] r_rep_cnt;
    logic             r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_deb_cnt <= '0;
            r_rep_cnt <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            if (r_sync2 != r_level) begin
                // Level flips only after DEB_CYC consecutive differing samples.
                if (r_deb_cnt == DEB_LAST) begin
                    r_level   <= r_sync2;
                    r_deb_cnt <= '0;
                    r_rep_cnt <= '0;
                    r_pulse   <= r_sync2;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DEB_W'(1);
                end
            end else begin
                r_deb_cnt <= '0;
                if (r_level) begin
                    if (r_rep_cnt == REP_LAST) begin
                        r_rep_cnt <= '0;
                        r_pulse   <= 1'b1;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + REP_W'(1);
                    end
                end
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM with debounced duty buttons; pending duty is applied to the
// active duty only at the counter wrap so a period is never cut short.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int CH         = 2,
    parameter int CNT_W      = 8,
    parameter int STEP       = 16,
    parameter int DEB_CYC    = 4,
    parameter int REPEAT_CYC = 64,
    parameter int DUTY_RST   = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CH-1:0]       inc_btn,
    input  logic [CH-1:0]       dec_btn,
    output logic [CH-1:0]       pwm_o,
    output logic [CH*CNT_W-1:0] duty_o,
    output logic                period_tick
);

    localparam logic [CNT_W-1:0] L_CNT_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] L_DUTY_RST = CNT_W'(DUTY_RST);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = ena && (r_cnt == L_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (ena) begin
            r_tick <= w_wrap;
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign period_tick = r_tick & ena;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic             w_inc_p;
        logic             w_dec_p;
        duty_evt_e        w_evt;
        logic [CNT_W-1:0] w_pend_nxt;
        logic [CNT_W-1:0] r_pend;
        logic [CNT_W-1:0] r_act;
        logic             r_pwm;

        pwm_btn_debounce #(
            .DEB_CYC    (DEB_CYC),
            .REPEAT_CYC (REPEAT_CYC)
        ) u_inc (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (inc_btn[i]),
            .o_pulse (w_inc_p)
        );

        pwm_btn_debounce #(
            .DEB_CYC    (DEB_CYC),
            .REPEAT_CYC (REPEAT_CYC)
        ) u_dec (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn   (dec_btn[i]),
            .o_pulse (w_dec_p)
        );

        // Pulses arriving while disabled are dropped, not deferred.
        always_comb begin
            w_pend_nxt = r_pend;
            w_evt      = ena ? decode_evt(w_inc_p, w_dec_p) : EVT_NONE;
            case (w_evt)
                EVT_INC: w_pend_nxt = CNT_W'(sat_add(int'(r_pend), STEP, duty_max(CNT_W)));
                EVT_DEC: w_pend_nxt = CNT_W'(sat_sub(int'(r_pend), STEP));
                default: w_pend_nxt = r_pend;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pend <= L_DUTY_RST;
                r_act  <= L_DUTY_RST;
                r_pwm  <= 1'b0;
            end else begin
                r_pend <= w_pend_nxt;
                if (w_wrap) begin
                    r_act <= r_pend;
                end
                r_pwm <= ena && (r_cnt < r_act);
            end
        end

        assign pwm_o[i]                             = r_pwm & ena;
        assign duty_o[ch_lsb(i, CNT_W) +: CNT_W]    = r_act;
    end

endmodule
